pixel_pack_writer: RTL
======================

PIXEL_PACK_WRITER -- requirements
Module: pixel_pack_writer

Interface
REQ-001 Parameter ADDR_W, default 32: width of the memory write address.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 frame_start  input  1  one-cycle pulse; starts a frame; honoured only in IDLE.
REQ-005 base_addr  input  ADDR_W  byte address of the first output word, sampled with frame_start.
REQ-006 pix_valid  input  1  pix_in carries a valid result pixel.
REQ-007 pix_in  input  8  edge-detector result pixel.
REQ-008 pix_last  input  1  qualifies the final pixel of the frame.
REQ-009 pix_ready  output  1  block accepts a pixel this cycle.
REQ-010 mem_req  output  1  write request to memory.
REQ-011 mem_addr  output  ADDR_W  word write address, byte-granular and 4-aligned relative to base_addr.
REQ-012 mem_data  output  32  packed write data.
REQ-013 mem_be  output  4  byte enables for mem_data.
REQ-014 mem_ack  input  1  memory has taken the current request.
REQ-015 busy  output  1  high in RUN and DRAIN.
REQ-016 done  output  1  one-cycle pulse when the frame's final word is acknowledged.

Function
REQ-017 The block SHALL implement states IDLE, RUN and DRAIN; pixel transfer occurs on any edge where pix_valid && pix_ready.
REQ-018 In IDLE, pix_ready SHALL be 0; frame_start SHALL load the address counter from base_addr, clear byte_cnt and enter RUN; frame_start outside IDLE SHALL be ignored.
REQ-019 Packing SHALL be little-endian: the pixel at byte_cnt=n goes to pack bits [8n+7:8n]; byte_cnt runs 0..3.
REQ-020 A pack word SHALL be complete when the pixel at byte_cnt=3 is accepted, or when any pixel with pix_last is accepted.
REQ-021 A completed pack word SHALL move to the output register on the same edge when the output register is empty or mem_ack is high that cycle; byte_cnt SHALL then return to 0.
REQ-022 pix_ready SHALL be 0 when the output register is full and byte_cnt=3, and 0 in DRAIN; otherwise 1 in RUN.
REQ-023 If a pix_last beat completes a word while the output register is full without mem_ack, the word SHALL be held pending; it SHALL transfer on the edge the output register frees.
REQ-024 Acceptance of a pix_last beat SHALL move RUN to DRAIN.
REQ-025 mem_req SHALL be 1 exactly while the output register is full; mem_addr, mem_data and mem_be SHALL stay stable from request until the edge where mem_ack is sampled high.
REQ-026 On each acknowledged word, the address counter SHALL increment by 4 modulo 2^ADDR_W (wrap from all-ones-minus-3 to 0).
REQ-027 mem_be SHALL be 4'b1111 for a full word and have the low k bits set for a partial last word of k pixels; unused bytes of mem_data SHALL be 0.
REQ-028 mem_ack while mem_req=0 SHALL be ignored.
REQ-029 In DRAIN, after the final word is acknowledged and no pending word remains, done SHALL pulse for 1 cycle and the state SHALL return to IDLE.
REQ-030 A frame whose last pixel lands at byte_cnt=3 SHALL produce no extra zero word.

Reset
REQ-031 With reset high at an edge, the block SHALL go to IDLE with byte_cnt=0, the pending flag cleared, the output register empty, the address counter at 0, and mem_req, mem_addr, mem_data, mem_be, pix_ready, busy and done all at 0.
REQ-032 Reset SHALL override every other input, including an outstanding request: mem_req SHALL be 0 the cycle after, with no done pulse.

Verification
REQ-033 base_addr=0x100, pixels 01..08, pix_last on 08, mem_ack one cycle after each request -> writes (0x100, 0x04030201, F) and (0x104, 0x08070605, F); one done pulse; return to IDLE.
REQ-034 Pixels 01..06 with pix_last on 06 -> second write (0x104, 0x00000605, be=0011).
REQ-035 Single pixel AA with pix_last -> one write, data 0x000000AA, be=0001, then done.
REQ-036 mem_ack withheld 6 cycles during a continuous stream -> request fields stable, pix_ready 0 once byte_cnt=3, no pixel lost; back-to-back transfer occurs on the ack edge.
REQ-037 base_addr=0xFFFFFFFC, 8 pixels -> addresses 0xFFFFFFFC then 0x00000000.
REQ-038 Reset asserted while mem_req=1 mid-frame -> next cycle all outputs 0 and IDLE; a new frame_start with base 0x200 writes its first word at 0x200.

Source files
------------

// File: rtl/pixel_pack_writer.sv
// Packs 8-bit result pixels little-endian into 32-bit words and writes them
// to memory through a single-entry request register with valid/ack handshake.
module pixel_pack_writer #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              pix_valid,
  input  logic [7:0]        pix_in,
  input  logic              pix_last,
  output logic              pix_ready,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BE_W   = 4;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0]   pack_q, pack_d;
  logic                pend_q, pend_d;
  logic [WORD_W-1:0]   pend_data_q, pend_data_d;
  logic [BE_W-1:0]     pend_be_q, pend_be_d;
  logic                out_full_q, out_full_d;
  logic [WORD_W-1:0]   out_data_q, out_data_d;
  logic [BE_W-1:0]     out_be_q, out_be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                pix_ready_q, pix_ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                accept_c;
  logic                ack_c;
  logic [WORD_W-1:0]   cur_word_c;
  logic [BE_W-1:0]     cur_be_c;

  // Word under construction with the current pixel merged at its byte lane.
  always_comb begin
    cur_word_c = pack_q | (WORD_W'(pix_in) << {byte_cnt_q, 3'b000});
    case (byte_cnt_q)
      2'd0:    cur_be_c = 4'b0001;
      2'd1:    cur_be_c = 4'b0011;
      2'd2:    cur_be_c = 4'b0111;
      default: cur_be_c = 4'b1111;
    endcase
  end

  assign accept_c = pix_valid && pix_ready_q;
  assign ack_c    = mem_ack && out_full_q;

  // Next-state and datapath: packing, output register handoff, address count.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    pack_d      = pack_q;
    pend_d      = pend_q;
    pend_data_d = pend_data_q;
    pend_be_d   = pend_be_q;
    out_full_d  = out_full_q;
    out_data_d  = out_data_q;
    out_be_d    = out_be_q;
    addr_d      = addr_q;
    done_d      = 1'b0;

    if (ack_c) begin
      out_full_d = 1'b0;
      addr_d     = addr_q + ADDR_W'(4);
    end

    case (state_q)
      S_IDLE: begin
        if (frame_start) begin
          addr_d     = base_addr;
          byte_cnt_d = '0;
          pack_d     = '0;
          pend_d     = 1'b0;
          state_d    = S_RUN;
        end
      end
      S_RUN: begin
        if (accept_c) begin
          if (byte_cnt_q == 2'd3 || pix_last) begin
            pack_d     = '0;
            byte_cnt_d = '0;
            if (!out_full_q || ack_c) begin
              out_full_d = 1'b1;
              out_data_d = cur_word_c;
              out_be_d   = cur_be_c;
            end else begin
              // Only a short last word can land here; a full word is stalled.
              pend_d      = 1'b1;
              pend_data_d = cur_word_c;
              pend_be_d   = cur_be_c;
            end
          end else begin
            pack_d     = cur_word_c;
            byte_cnt_d = CNT_W'(byte_cnt_q + 2'd1);
          end
          if (pix_last) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (ack_c) begin
          if (pend_q) begin
            out_full_d = 1'b1;
            out_data_d = pend_data_q;
            out_be_d   = pend_be_q;
            pend_d     = 1'b0;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    pix_ready_d = (state_d == S_RUN) && !(out_full_d && byte_cnt_d == 2'd3);
    busy_d      = (state_d != S_IDLE);
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      byte_cnt_q  <= '0;
      pack_q      <= '0;
      pend_q      <= 1'b0;
      pend_data_q <= '0;
      pend_be_q   <= '0;
      out_full_q  <= 1'b0;
      out_data_q  <= '0;
      out_be_q    <= '0;
      addr_q      <= '0;
      pix_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      pack_q      <= pack_d;
      pend_q      <= pend_d;
      pend_data_q <= pend_data_d;
      pend_be_q   <= pend_be_d;
      out_full_q  <= out_full_d;
      out_data_q  <= out_data_d;
      out_be_q    <= out_be_d;
      addr_q      <= addr_d;
      pix_ready_q <= pix_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign pix_ready = pix_ready_q;
  assign mem_req   = out_full_q;
  assign mem_addr  = addr_q;
  assign mem_data  = out_data_q;
  assign mem_be    = out_be_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
